mmio_sig_unit: RTL
==================

// Module: mmio_sig_unit
// PURPOSE
//  Memory-mapped test-host peripheral on the core's data-memory write port.
//  Splits core stores into normal memory writes (addr[31:28]==0), signature words
//  (SIG_ADDR) and halt requests (HALT_ADDR + HALT_DATA). Buffers signature words in
//  a FIFO, drains them on a valid/ready stream, and raises done after the halt store
//  once every buffered word has been drained.
// PARAMETERS
//  FIFO_DEPTH  8             signature FIFO entries; power of 2, >=2
//  SIG_ADDR    32'hF0000004  store address that pushes a signature word
//  HALT_ADDR   32'hCAFECAFE  store address of the halt request
//  HALT_DATA   32'hF0000000  store data required with HALT_ADDR
// PORTS
//  sysclk        in   1   clock; all state updates on posedge
//  rst_in        in   1   synchronous reset, active-high
//  dmem_wr_addr  in   32  core store address
//  dmem_wr_data  in   32  core store data
//  dmem_wr_en    in   1   core store strobe, one store per cycle
//  mem_wr_en     out  1   write enable to main memory (combinational)
//  sig_valid     out  1   FIFO head holds a word
//  sig_data      out  32  FIFO head word
//  sig_ready     in   1   consumer accepts head when sig_valid=1
//  sig_count     out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
//  overflow      out  1   sticky: a signature word was dropped
//  halt_req      out  1   halt store seen (state DRAIN or DONE)
//  done          out  1   halt seen and FIFO drained (state DONE)
// BEHAVIOUR
//  - Reset: FIFO empty, sig_valid=0, sig_count=0, overflow=0, halt_req=0, done=0,
//    state RUN. Reset mid-operation discards buffered words; no partial output.
//  - mem_wr_en = dmem_wr_en & (dmem_wr_addr[31:28]==4'h0); never registered.
//  - push = dmem_wr_en & addr==SIG_ADDR & state!=DONE. pop = sig_valid & sig_ready.
//  - FIFO is first-word-fall-through: sig_valid = (count!=0), sig_data = head entry.
//    A word stored at edge N appears on sig_data after edge N (1-cycle latency).
//  - sig_data stable while sig_valid & !sig_ready.
//  - Push and pop in the same cycle: both take effect, count unchanged; allowed when
//    full (pop frees the slot). Push when full and no pop: word dropped, overflow<=1,
//    stays 1 until reset. Pop when empty impossible (sig_valid=0).
//  - Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
//  - halt = dmem_wr_en & addr==HALT_ADDR & data==HALT_DATA. HALT_ADDR with other
//    data: ignored (no memory write, no push, no state change).
//    Stores to all other non-memory addresses are ignored.
//  - FSM:
//    RUN   -> DRAIN on halt.
//    DRAIN: halt_req=1; pushes still accepted.
//           -> DONE at an edge where (count==0 & !push) or (count==1 & pop & !push).
//    DONE:  halt_req=1, done=1; pushes ignored (no overflow); only reset exits.
//    A repeated halt in DRAIN/DONE has no effect.
//  - Halt store with empty FIFO: DRAIN after edge N, DONE after edge N+1.
// TESTING
//  1 reset, sig_ready=1; store 0x00000010<-0x11; store 0xF0000004<-0xA5 -> mem_wr_en=1
//    for first store only; sig_valid=1, sig_data=0xA5 one cycle after second store.
//  2 sig_ready=0; 8 stores to SIG_ADDR (data 1..8) -> sig_count=8, overflow=0; 9th
//    store -> sig_count=8, overflow=1; set ready -> words 1..8 drained in order.
//  3 FIFO full, sig_ready=1, push in same cycle -> count stays 8, overflow=0, order kept.
//  4 3 words queued, ready=0; halt store -> halt_req=1, done=0; ready=1 -> done=1 at
//    edge after last pop; a later SIG_ADDR store is not pushed.
//  5 HALT_ADDR with data 0x0 -> halt_req=0; empty FIFO + valid halt -> done 2 edges later.
//  6 rst_in high mid-drain with 5 words queued -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/mmio_sig_unit_if.sv
// Core store port plus signature stream and status of mmio_sig_unit.
// Latency: none (wires only). Backpressure: sig_ready from the consumer holds the stream head.
// Ports: master = core/test host side, slave = mmio_sig_unit.
//   dmem_wr_addr/dmem_wr_data/dmem_wr_en : core store (master -> slave)
//   mem_wr_en                            : main-memory write enable (slave -> master)
//   sig_valid/sig_data/sig_ready         : signature word stream
//   sig_count/overflow/halt_req/done     : status (slave -> master)
interface mmio_sig_unit_if #(
  parameter int FIFO_DEPTH = 8
) ();
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   dmem_wr_addr;
  logic [31:0]   dmem_wr_data;
  logic          dmem_wr_en;
  logic          mem_wr_en;
  logic          sig_valid;
  logic [31:0]   sig_data;
  logic          sig_ready;
  logic [CW-1:0] sig_count;
  logic          overflow;
  logic          halt_req;
  logic          done;

  modport master (
    output dmem_wr_addr, dmem_wr_data, dmem_wr_en, sig_ready,
    input  mem_wr_en, sig_valid, sig_data, sig_count, overflow, halt_req, done
  );

  modport slave (
    input  dmem_wr_addr, dmem_wr_data, dmem_wr_en, sig_ready,
    output mem_wr_en, sig_valid, sig_data, sig_count, overflow, halt_req, done
  );
endinterface

// File: rtl/mmio_sig_unit.sv
// Test-host MMIO peripheral: splits core stores into memory writes, signature words and halt.
// Latency: mem_wr_en combinational; a signature word appears on sig_data one cycle after its store.
// Backpressure: sig_ready=0 holds the FIFO head; a push into a full FIFO with no pop is dropped
// and sets the sticky overflow flag.
// Ports: sysclk (clock), rst_in (sync active-high reset), bus (mmio_sig_unit_if.slave).
module mmio_sig_unit #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] SIG_ADDR   = 32'hF000_0004,
  parameter logic [31:0] HALT_ADDR  = 32'hCAFE_CAFE,
  parameter logic [31:0] HALT_DATA  = 32'hF000_0000
) (
  input logic            sysclk,
  input logic            rst_in,
  mmio_sig_unit_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e        state_q,    state_d;
  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0] count_q,    count_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   mem_q [FIFO_DEPTH];

  logic push;
  logic pop;
  logic halt;
  logic full;
  logic wr_ok;

  always_comb begin
    push  = bus.dmem_wr_en && (bus.dmem_wr_addr == SIG_ADDR) && (state_q != ST_DONE);
    halt  = bus.dmem_wr_en && (bus.dmem_wr_addr == HALT_ADDR) && (bus.dmem_wr_data == HALT_DATA);
    pop   = (count_q != '0) && bus.sig_ready;
    full  = (count_q == CW'(FIFO_DEPTH));
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    wr_ok = push && (!full || pop);

    wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    if (wr_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!wr_ok && pop) begin
      count_d = count_q - 1'b1;
    end

    overflow_d = overflow_q || (push && full && !pop);
  end

  // Halt handshake: DRAIN waits until the FIFO will be empty after this edge
  // with nothing new arriving; DONE is terminal until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (halt) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!push && ((count_q == '0) || ((count_q == CW'(1)) && pop))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst_in) begin
      state_q    <= ST_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; sig_valid gates the stale contents.
  always_ff @(posedge sysclk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= bus.dmem_wr_data;
  end

  assign bus.mem_wr_en = bus.dmem_wr_en && (bus.dmem_wr_addr[31:28] == 4'h0);
  assign bus.sig_valid = (count_q != '0);
  assign bus.sig_data  = mem_q[rd_ptr_q];
  assign bus.sig_count = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.halt_req  = (state_q != ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
endmodule
